// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and widths for the i2c_req_arbiter slice: FSM state encoding
// and the address/data/timeout-counter widths.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int TO_W   = 15;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and i2c_dri-side signals of the arbiter. The master modport is the
// arbiter's view; the slave modport is the view of the requesters plus i2c_dri.
interface i2c_req_arbiter_if
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_rh_wl;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;
    logic [DATA_W-1:0]         req_rdata;
    logic                      busy;
    logic                      i2c_exec;
    logic [ADDR_W-1:0]         i2c_addr;
    logic [DATA_W-1:0]         i2c_data_w;
    logic                      i2c_rh_wl;
    logic                      i2c_done;
    logic [DATA_W-1:0]         i2c_data_r;

    modport master (
        input  req, req_addr, req_wdata, req_rh_wl, i2c_done, i2c_data_r,
        output req_done, req_err, req_rdata, busy,
               i2c_exec, i2c_addr, i2c_data_w, i2c_rh_wl
    );

    modport slave (
        output req, req_addr, req_wdata, req_rh_wl, i2c_done, i2c_data_r,
        input  req_done, req_err, req_rdata, busy,
               i2c_exec, i2c_addr, i2c_data_w, i2c_rh_wl
    );
endinterface

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request bit searching upward from
// last_grant+1 with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      grant,
    output logic               any_req
);
    logic [GW-1:0] idx_s;
    logic          found_s;

    // Rotating priority search; the requester just served is checked last.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx_s   = GW'((int'(last_grant) + off) % NUM_REQ);
            grant   = (!found_s && req[idx_s]) ? idx_s : grant;
            found_s = found_s | req[idx_s];
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_dri master between NUM_REQ requesters.
// Optional transaction timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 20000
) (
    input logic               clk,
    input logic               rst,
    i2c_req_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32768) begin : g_param_check
        $error("i2c_req_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
    end

    arb_state_e         state_r, state_nxt_s;
    logic [GW-1:0]      grant_s, grant_r, last_grant_r;
    logic               any_req_s, timeout_s;
    logic [ADDR_W-1:0]  addr_sel_s, i2c_addr_r;
    logic [DATA_W-1:0]  wdata_sel_s, i2c_data_w_r, req_rdata_r;
    logic               rh_wl_sel_s, i2c_rh_wl_r;
    logic               i2c_exec_r, busy_r;
    logic [NUM_REQ-1:0] req_done_r;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
        .req        (bus.req),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .any_req    (any_req_s)
    );

    // Steer the winning requester's payload toward the latches.
    always_comb begin
        addr_sel_s  = '0;
        wdata_sel_s = '0;
        rh_wl_sel_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_sel_s  = (grant_s == GW'(k)) ? bus.req_addr[k*ADDR_W +: ADDR_W]  : addr_sel_s;
            wdata_sel_s = (grant_s == GW'(k)) ? bus.req_wdata[k*DATA_W +: DATA_W] : wdata_sel_s;
            rh_wl_sel_s = (grant_s == GW'(k)) ? bus.req_rh_wl[k]                  : rh_wl_sel_s;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_r;
    logic [NUM_REQ-1:0] req_err_r;

    // Timeout counter: cleared while issuing, counts WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r <= '0;
        end else if (state_r == EXEC) begin
            to_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // A real i2c_done in the expiry cycle wins over the timeout.
    assign timeout_s = (state_r == WAIT) && !bus.i2c_done &&
                       (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

    // Error pulse accompanies the req_done of a timed-out transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_err_r <= '0;
        end else begin
            req_err_r <= timeout_s ? onehot(grant_r) : '0;
        end
    end

    assign bus.req_err = req_err_r;
`else
    assign timeout_s   = 1'b0;
    assign bus.req_err = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; i2c_done is only honoured in WAIT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = any_req_s ? EXEC : IDLE;
            EXEC:    state_nxt_s = WAIT;
            WAIT:    state_nxt_s = (bus.i2c_done || timeout_s) ? DONE : WAIT;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Registered outputs decoded from next state, plus grant and payload latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r      <= '0;
            last_grant_r <= GW'(NUM_REQ - 1);
            i2c_exec_r   <= 1'b0;
            busy_r       <= 1'b0;
            req_done_r   <= '0;
            req_rdata_r  <= '0;
            i2c_addr_r   <= '0;
            i2c_data_w_r <= '0;
            i2c_rh_wl_r  <= 1'b0;
        end else begin
            i2c_exec_r <= (state_nxt_s == EXEC);
            busy_r     <= (state_nxt_s != IDLE);
            req_done_r <= (state_nxt_s == DONE) ? onehot(grant_r) : '0;
            if (state_r == IDLE && any_req_s) begin
                grant_r      <= grant_s;
                i2c_addr_r   <= addr_sel_s;
                i2c_data_w_r <= wdata_sel_s;
                i2c_rh_wl_r  <= rh_wl_sel_s;
            end else begin
                grant_r      <= grant_r;
                i2c_addr_r   <= i2c_addr_r;
                i2c_data_w_r <= i2c_data_w_r;
                i2c_rh_wl_r  <= i2c_rh_wl_r;
            end
            if (state_r == WAIT && bus.i2c_done) begin
                req_rdata_r <= bus.i2c_data_r;
            end else if (timeout_s) begin
                req_rdata_r <= 8'hFF;
            end else begin
                req_rdata_r <= req_rdata_r;
            end
            last_grant_r <= (state_r == DONE) ? grant_r : last_grant_r;
        end
    end

    assign bus.i2c_exec   = i2c_exec_r;
    assign bus.busy       = busy_r;
    assign bus.req_done   = req_done_r;
    assign bus.req_rdata  = req_rdata_r;
    assign bus.i2c_addr   = i2c_addr_r;
    assign bus.i2c_data_w = i2c_data_w_r;
    assign bus.i2c_rh_wl  = i2c_rh_wl_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed + randomized bench for i2c_req_arbiter against a round-robin reference
// model. Define I2C_ARB_TIMEOUT_EN to exercise the timeout path with TIMEOUT_CYC=100.
module tb_i2c_req_arbiter;
    localparam int NUM_REQ = 2;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_CYC = 100;
`else
    localparam int TO_CYC = 20000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_exec_cyc = -1;
    int   model_last = NUM_REQ - 1;
    int   waited;

    logic [NUM_REQ-1:0] pend = '0;
    logic [15:0]        m_addr  [NUM_REQ];
    logic [7:0]         m_wdata [NUM_REQ];
    logic               m_rh    [NUM_REQ];

    i2c_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    i2c_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending requester after the last one served.
    function automatic int model_pick(input logic [NUM_REQ-1:0] p);
        for (int off = 1; off <= NUM_REQ; off++) begin
            int k;
            k = (model_last + off) % NUM_REQ;
            if (p[k]) return k;
        end
        return -1;
    endfunction

    task automatic new_payload(input int k);
        m_addr[k]  = {4'(k), 12'($urandom)};
        m_wdata[k] = 8'($urandom);
        m_rh[k]    = 1'($urandom);
    endtask

    task automatic drive_bus();
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_addr[k*16 +: 16] = m_addr[k];
            bus.req_wdata[k*8 +: 8]  = m_wdata[k];
            bus.req_rh_wl[k]         = m_rh[k];
        end
        bus.req = pend;
    endtask

    task automatic wait_exec(output int w);
        w = 0;
        @(negedge clk);
        while (bus.i2c_exec !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("exec_seen", 32'(bus.i2c_exec), 32'd1);
        if (bus.i2c_exec === 1'b1 && last_exec_cyc >= 0)
            check("exec_spacing", 32'((cyc - last_exec_cyc) >= 4), 32'd1);
        last_exec_cyc = cyc;
    endtask

    // One full transaction; ends at the negedge inside the req_done cycle.
    task automatic run_txn(input logic [7:0] rd, input int delay, input bit stray,
                           input bit drop, output int w);
        int g;
        g = model_pick(pend);
        wait_exec(w);
        if (bus.i2c_exec !== 1'b1 || g < 0) return;
        check("i2c_addr", 32'(bus.i2c_addr), 32'(m_addr[g]));
        check("i2c_data_w", 32'(bus.i2c_data_w), 32'(m_wdata[g]));
        check("i2c_rh_wl", 32'(bus.i2c_rh_wl), 32'(m_rh[g]));
        check("done_quiet_exec", 32'(bus.req_done), 32'd0);
        if (stray) begin
            bus.i2c_done   = 1'b1;
            bus.i2c_data_r = 8'hEE;
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            bus.i2c_done = 1'b0;
            check("busy_wait", 32'(bus.busy), 32'd1);
            check("done_quiet_wait", 32'(bus.req_done), 32'd0);
        end
        bus.i2c_done   = 1'b1;
        bus.i2c_data_r = rd;
        @(negedge clk);
        bus.i2c_done   = 1'b0;
        bus.i2c_data_r = 8'h00;
        check("req_done", 32'(bus.req_done), 32'(1 << g));
        check("req_rdata", 32'(bus.req_rdata), 32'(rd));
        check("req_err", 32'(bus.req_err), 32'd0);
        model_last = g;
        if (drop) begin
            pend[g] = 1'b0;
            bus.req = pend;
        end
    endtask

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            m_addr[k] = '0; m_wdata[k] = '0; m_rh[k] = 1'b0;
        end
        bus.i2c_done   = 1'b0;
        bus.i2c_data_r = 8'h00;
        drive_bus();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_exec", 32'(bus.i2c_exec), 32'd0);
        check("rst_done", 32'(bus.req_done), 32'd0);
        check("rst_rdata", 32'(bus.req_rdata), 32'd0);
        check("rst_addr", 32'(bus.i2c_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write from requester 0
        m_addr[0] = 16'h1281; m_wdata[0] = 8'h3A; m_rh[0] = 1'b0;
        pend = 2'b01;
        drive_bus();
        run_txn(8'h00, 40, 1'b0, 1'b1, waited);
        check("req_to_exec_latency", 32'(waited), 32'd0);

        // Read from requester 1
        @(negedge clk);
        m_addr[1] = 16'h2A07; m_wdata[1] = 8'h00; m_rh[1] = 1'b1;
        pend = 2'b10;
        drive_bus();
        run_txn(8'h5C, 5, 1'b0, 1'b1, waited);

        // Contention: both held for four transactions
        new_payload(0); new_payload(1);
        pend = 2'b11;
        drive_bus();
        for (int t = 0; t < 4; t++) run_txn(8'($urandom), $urandom_range(1, 4), 1'b0, 1'b0, waited);
        pend = '0;
        drive_bus();

        // Stray done in IDLE
        repeat (2) @(negedge clk);
        bus.i2c_done = 1'b1;
        @(negedge clk);
        bus.i2c_done = 1'b0;
        check("stray_idle_busy", 32'(bus.busy), 32'd0);
        check("stray_idle_done", 32'(bus.req_done), 32'd0);
        @(negedge clk);
        check("stray_idle_busy2", 32'(bus.busy), 32'd0);

        // Randomized traffic, including stray done in the EXEC cycle
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    new_payload(k);
                    pend[k] = 1'b1;
                end
            end
            if (pend == '0) begin
                new_payload(it % NUM_REQ);
                pend[it % NUM_REQ] = 1'b1;
            end
            drive_bus();
            run_txn(8'($urandom), $urandom_range(1, 6), 1'($urandom), 1'($urandom), waited);
        end
        pend = '0;
        drive_bus();
        repeat (2) @(negedge clk);

        // Reset mid-WAIT
        new_payload(0); new_payload(1);
        pend = 2'b11;
        drive_bus();
        wait_exec(waited);
        check("pre_rst_addr", 32'(bus.i2c_addr), 32'(m_addr[model_pick(pend)]));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_exec", 32'(bus.i2c_exec), 32'd0);
        check("midrst_done", 32'(bus.req_done), 32'd0);
        model_last = NUM_REQ - 1;
        run_txn(8'h11, 2, 1'b0, 1'b1, waited);
        run_txn(8'h22, 2, 1'b0, 1'b1, waited);
        repeat (2) @(negedge clk);

        // Requester 0 with no i2c_done ever returned
        new_payload(0);
        pend = 2'b01;
        drive_bus();
        wait_exec(waited);
`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int early;
            early = 0;
            for (int i = 1; i <= TO_CYC; i++) begin
                @(negedge clk);
                if (bus.req_done !== '0) early++;
            end
            check("timeout_no_early_done", 32'(early), 32'd0);
            @(negedge clk);
            check("timeout_done", 32'(bus.req_done), 32'd1);
            check("timeout_err", 32'(bus.req_err), 32'd1);
            check("timeout_rdata", 32'(bus.req_rdata), 32'hFF);
        end
`else
        repeat (300) @(negedge clk);
        check("no_timeout_busy", 32'(bus.busy), 32'd1);
        check("no_timeout_done", 32'(bus.req_done), 32'd0);
`endif
        pend = '0;
        drive_bus();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
